// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master transaction sequencer: state encoding,
// start-bit polarities and the processor register width.
package spi_master_ctrl_pkg;

  localparam int REGISTER_SIZE = 32;

  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000001,
    ST_START     = 6'b000010,
    ST_SHIFT_OUT = 6'b000100,
    ST_WAIT_RESP = 6'b001000,
    ST_SHIFT_IN  = 6'b010000,
    ST_DONE      = 6'b100000
  } spi_ctrl_state_t;

  localparam logic SPI_MOSI_START = 1'b1;
  localparam logic SPI_MISO_IDLE  = 1'b0;
  localparam logic SPI_MISO_START = 1'b1;

endpackage

// File: rtl/Spi.sv
// Shared SPI bus: one sclk, one nss line per slave, mosi and miso.
interface Spi #(
  parameter int NUM_SLAVES = 3
);
  logic                  sclk;
  logic [NUM_SLAVES-1:0] nss;
  logic                  mosi;
  logic                  miso;

  modport master (output sclk, output nss, output mosi, input miso);
  modport slave  (input sclk, input nss, input mosi, output miso);
endinterface

// File: rtl/spi_bit_counter.sv
// Bit counter with synchronous clear and terminal-count compare; one instance
// is shared by the outbound and inbound shift phases.
module spi_bit_counter #(
  parameter int WIDTH = 7
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge i_clock) begin
    if (!i_reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_terminal = (count == terminal);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transaction sequencer: start bit, packet out, wait for the slave
// start bit, response in. Optional wait timeout via `SPI_CTRL_TIMEOUT_EN.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int NUM_SLAVES     = 3,
  parameter int MAX_TX_WIDTH   = 72,
  parameter int RX_WIDTH       = REGISTER_SIZE,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_req,
  output logic                              o_ready,
  input  logic [$clog2(NUM_SLAVES)-1:0]     i_slave,
  input  logic [$clog2(MAX_TX_WIDTH+1)-1:0] i_tx_len,
  input  logic [MAX_TX_WIDTH-1:0]           i_tx_data,
  output logic                              o_done,
  output logic [RX_WIDTH-1:0]               o_rx_data,
  output logic                              o_error,
  Spi.master                                spi
);

  localparam int LEN_W = $clog2(MAX_TX_WIDTH + 1);
  localparam int CNT_W = $clog2((MAX_TX_WIDTH > RX_WIDTH) ? MAX_TX_WIDTH : RX_WIDTH);

  spi_ctrl_state_t         state;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        len_in;
  logic [MAX_TX_WIDTH-1:0] tx_shift;
  logic [RX_WIDTH-2:0]     rx_shift;
  logic [NUM_SLAVES-1:0]   nss_q;
  logic [NUM_SLAVES-1:0]   nss_sel;
  logic                    mosi_q;
  logic                    slave_ok;
  logic                    cnt_clr;
  logic                    cnt_en;
  logic                    cnt_done;
  logic [CNT_W-1:0]        cnt_term;
  logic                    wait_expired;

  always_comb begin
    len_in = i_tx_len;
    if (i_tx_len == '0 || i_tx_len > LEN_W'(MAX_TX_WIDTH)) begin
      len_in = LEN_W'(MAX_TX_WIDTH);
    end
  end

  assign slave_ok = (int'(i_slave) < NUM_SLAVES);
  assign nss_sel  = ~(NUM_SLAVES'(1) << i_slave);

  assign cnt_en   = (state == ST_SHIFT_OUT) || (state == ST_SHIFT_IN);
  assign cnt_clr  = (state == ST_IDLE) || ((state == ST_SHIFT_OUT) && cnt_done);
  assign cnt_term = (state == ST_SHIFT_OUT) ? CNT_W'(len_q - LEN_W'(1))
                                            : CNT_W'(RX_WIDTH - 1);

  spi_bit_counter #(
    .WIDTH (CNT_W)
  ) u_bit_counter (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .clear       (cnt_clr),
    .enable      (cnt_en),
    .terminal    (cnt_term),
    .at_terminal (cnt_done)
  );

`ifdef SPI_CTRL_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;

  // Counts consecutive cycles spent waiting on a handshake; any state change clears it.
  assign waiting = ((state == ST_START)     && (spi.miso != SPI_MISO_IDLE)) ||
                   ((state == ST_WAIT_RESP) && (spi.miso != SPI_MISO_START));
  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wait_cnt <= '0;
    end else if (waiting && !wait_expired) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign wait_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
      o_error   <= 1'b0;
      o_rx_data <= '0;
      nss_q     <= '1;
      mosi_q    <= 1'b0;
      len_q     <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_req) begin
            len_q    <= len_in;
            tx_shift <= i_tx_data;
            o_ready  <= 1'b0;
            if (slave_ok) begin
              state  <= ST_START;
              nss_q  <= nss_sel;
              mosi_q <= SPI_MOSI_START;
            end else begin
              state   <= ST_DONE;
              o_done  <= 1'b1;
              o_error <= 1'b1;
            end
          end
        end
        ST_START: begin
          if (spi.miso == SPI_MISO_IDLE) begin
            state    <= ST_SHIFT_OUT;
            mosi_q   <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end else if (wait_expired) begin
            state   <= ST_DONE;
            nss_q   <= '1;
            mosi_q  <= 1'b0;
            o_done  <= 1'b1;
            o_error <= 1'b1;
          end
        end
        ST_SHIFT_OUT: begin
          if (cnt_done) begin
            state  <= ST_WAIT_RESP;
            mosi_q <= 1'b0;
          end else begin
            mosi_q   <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
        end
        ST_WAIT_RESP: begin
          if (spi.miso == SPI_MISO_START) begin
            state <= ST_SHIFT_IN;
          end else if (wait_expired) begin
            state   <= ST_DONE;
            nss_q   <= '1;
            o_done  <= 1'b1;
            o_error <= 1'b1;
          end
        end
        ST_SHIFT_IN: begin
          // LSB arrives first, so new bits enter at the top and drift down.
          rx_shift <= {spi.miso, rx_shift[RX_WIDTH-2:1]};
          if (cnt_done) begin
            state     <= ST_DONE;
            nss_q     <= '1;
            o_done    <= 1'b1;
            o_rx_data <= {spi.miso, rx_shift};
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          o_ready <= 1'b1;
          o_error <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          o_ready <= 1'b1;
          o_error <= 1'b0;
          nss_q   <= '1;
          mosi_q  <= 1'b0;
        end
      endcase
    end
  end

  assign spi.sclk = i_clock;
  assign spi.nss  = nss_q;
  assign spi.mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: a cycle-scheduled ALU-style slave drives
// miso while each scenario task checks latency, bus levels and received data.
module tb_spi_master_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        ready;
  logic [1:0]  slave;
  logic [6:0]  tx_len;
  logic [71:0] tx_data;
  logic        done;
  logic [31:0] rx_data;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  Spi #(.NUM_SLAVES(3)) spi_bus ();

  spi_master_ctrl #(
    .NUM_SLAVES     (3),
    .MAX_TX_WIDTH   (72),
    .RX_WIDTH       (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_req     (req),
    .o_ready   (ready),
    .i_slave   (slave),
    .i_tx_len  (tx_len),
    .i_tx_data (tx_data),
    .o_done    (done),
    .o_rx_data (rx_data),
    .o_error   (error),
    .spi       (spi_bus)
  );

  // Slave-side behaviour: {a[31:0], b[31:0], op[2:0]} -> result.
  function automatic logic [31:0] alu_model(input logic [71:0] p);
    logic [31:0] a;
    logic [31:0] b;
    a = p[66:35];
    b = p[34:3];
    case (p[2:0])
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      default: return '0;
    endcase
  endfunction

  // Starts at a negedge in IDLE; returns at the negedge of the o_done cycle
  // (cycle 1 = first cycle after the accepting edge), or -1 after 400 cycles.
  task automatic do_txn(input logic [1:0] sl, input logic [6:0] len, input logic [71:0] data,
                        input int s_hold, input int w_hold, input bit keep_req,
                        output int done_cyc, output logic [31:0] rx, output logic err,
                        output logic [71:0] cap, output bit bus_ok);
    int ts;
    int k;
    int eff_len;
    logic [31:0] reply;
    logic [2:0]  nss_exp;
    nss_exp  = ~(3'b001 << sl);
    eff_len  = (len == 0 || len > 72) ? 72 : int'(len);
    ts       = s_hold + 1;
    done_cyc = -1;
    rx       = '0;
    err      = 1'b0;
    cap      = '0;
    bus_ok   = 1'b1;
    reply    = '0;
    slave    = sl;
    tx_len   = len;
    tx_data  = data;
    req      = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (!keep_req) req = 1'b0;
      tx_data = ~data;
      tx_len  = 7'd5;
      if (done) begin
        done_cyc = c;
        rx       = rx_data;
        err      = error;
        if (spi_bus.nss !== 3'b111) bus_ok = 1'b0;
        break;
      end
      if (spi_bus.nss !== nss_exp || ready !== 1'b0) bus_ok = 1'b0;
      if (c <= ts) begin
        if (spi_bus.mosi !== 1'b1) bus_ok = 1'b0;
        spi_bus.miso = (c < ts);
      end else if (c <= ts + eff_len) begin
        cap[c-ts-1]  = spi_bus.mosi;
        spi_bus.miso = 1'b0;
      end else if (c <= ts + eff_len + w_hold + 1) begin
        if (spi_bus.mosi !== 1'b0) bus_ok = 1'b0;
        if (c == ts + eff_len + 1) reply = alu_model(cap);
        spi_bus.miso = (c == ts + eff_len + w_hold + 1);
      end else begin
        k = c - (ts + eff_len + w_hold + 2);
        spi_bus.miso = (k < 32) ? reply[k] : 1'b0;
      end
    end
    spi_bus.miso = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
    n_checks++; if (spi_bus.nss !== 3'b111) $display("FAIL reset_nss: got %b want 111", spi_bus.nss); else n_pass++;
    n_checks++; if (spi_bus.mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", spi_bus.mosi); else n_pass++;
    n_checks++; if (rx_data !== 32'd0) $display("FAIL reset_rx: got %0d want 0", rx_data); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_add();
    int dc; logic [31:0] rx; logic err; logic [71:0] cap; bit ok;
    logic [71:0] pkt;
    pkt = {5'd0, 32'd5, 32'd7, 3'd0};
    do_txn(2'd0, 7'd67, pkt, 0, 0, 1'b0, dc, rx, err, cap, ok);
    n_checks++; if (dc !== 102) $display("FAIL add_latency: got %0d want 102", dc); else n_pass++;
    n_checks++; if (rx !== 32'd12) $display("FAIL add_rx: got %0d want 12", rx); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL add_error: got %b want 0", err); else n_pass++;
    n_checks++; if (ok !== 1'b1) $display("FAIL add_bus: got %b want 1", ok); else n_pass++;
    n_checks++; if (cap !== pkt) $display("FAIL add_mosi: got %h want %h", cap, pkt); else n_pass++;
    @(negedge clk);
    n_checks++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL add_idle: got ready=%b done=%b want 1 0", ready, done); else n_pass++;
  endtask

  task automatic test_delayed_slave();
    int dc; logic [31:0] rx; logic err; logic [71:0] cap; bit ok;
    do_txn(2'd2, 7'd67, {5'd0, 32'd6, 32'd9, 3'd2}, 5, 10, 1'b0, dc, rx, err, cap, ok);
    n_checks++; if (dc !== 117) $display("FAIL delay_latency: got %0d want 117", dc); else n_pass++;
    n_checks++; if (rx !== 32'd54) $display("FAIL delay_rx: got %0d want 54", rx); else n_pass++;
    n_checks++; if (ok !== 1'b1 || err !== 1'b0) $display("FAIL delay_bus: got ok=%b err=%b want 1 0", ok, err); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_bad_slave();
    slave   = 2'd3;
    tx_len  = 7'd8;
    tx_data = 72'hFF;
    req     = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n_checks++; if (done !== 1'b1 || error !== 1'b1) $display("FAIL bad_done: got done=%b err=%b want 1 1", done, error); else n_pass++;
    n_checks++; if (spi_bus.nss !== 3'b111) $display("FAIL bad_nss: got %b want 111", spi_bus.nss); else n_pass++;
    n_checks++; if (rx_data !== 32'd54) $display("FAIL bad_rx: got %0d want 54", rx_data); else n_pass++;
    n_checks++; if (ready !== 1'b0) $display("FAIL bad_ready_done: got %b want 0", ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || error !== 1'b0 || ready !== 1'b1) $display("FAIL bad_after: got done=%b err=%b ready=%b want 0 0 1", done, error, ready); else n_pass++;
  endtask

  task automatic test_len_clamp();
    int dc; logic [31:0] rx; logic err; logic [71:0] cap; bit ok;
    logic [71:0] pkt;
    pkt = {5'b10101, 32'd2, 32'd3, 3'd0};
    do_txn(2'd1, 7'd0, pkt, 0, 0, 1'b0, dc, rx, err, cap, ok);
    n_checks++; if (dc !== 107) $display("FAIL clamp_latency: got %0d want 107", dc); else n_pass++;
    n_checks++; if (cap !== pkt) $display("FAIL clamp_mosi: got %h want %h", cap, pkt); else n_pass++;
    n_checks++; if (rx !== 32'd5 || ok !== 1'b1) $display("FAIL clamp_rx: got %0d ok=%b want 5 1", rx, ok); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dc; logic [31:0] rx; logic err; logic [71:0] cap; bit ok;
    do_txn(2'd0, 7'd67, {5'd0, 32'd100, 32'd58, 3'd1}, 0, 0, 1'b1, dc, rx, err, cap, ok);
    n_checks++; if (dc !== 102) $display("FAIL busy_latency: got %0d want 102", dc); else n_pass++;
    n_checks++; if (rx !== 32'd42) $display("FAIL busy_rx: got %0d want 42", rx); else n_pass++;
    @(negedge clk);
    n_checks++; if (ready !== 1'b1 || done !== 1'b0 || spi_bus.nss !== 3'b111) $display("FAIL busy_idle: got ready=%b done=%b nss=%b want 1 0 111", ready, done, spi_bus.nss); else n_pass++;
    do_txn(2'd1, 7'd67, {5'd0, 32'd20, 32'd25, 3'd0}, 0, 0, 1'b0, dc, rx, err, cap, ok);
    n_checks++; if (dc !== 102) $display("FAIL b2b_latency: got %0d want 102", dc); else n_pass++;
    n_checks++; if (rx !== 32'd45 || ok !== 1'b1) $display("FAIL b2b_rx: got %0d ok=%b want 45 1", rx, ok); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dc; logic [31:0] rx; logic err; logic [71:0] cap; bit ok;
    int n_done;
    slave   = 2'd0;
    tx_len  = 7'd67;
    tx_data = {5'd0, 32'd9, 32'd9, 3'd0};
    req     = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      req          = 1'b0;
      spi_bus.miso = 1'b0;
    end
    n_checks++; if (spi_bus.nss !== 3'b110) $display("FAIL rmid_active: got %b want 110", spi_bus.nss); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (spi_bus.nss !== 3'b111) $display("FAIL rmid_nss: got %b want 111", spi_bus.nss); else n_pass++;
    n_checks++; if (ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", ready); else n_pass++;
    n_checks++; if (rx_data !== 32'd0) $display("FAIL rmid_rx: got %0d want 0", rx_data); else n_pass++;
    n_done = (done === 1'b1) ? 1 : 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    n_checks++; if (n_done !== 0) $display("FAIL rmid_no_done: got %0d want 0", n_done); else n_pass++;
    do_txn(2'd0, 7'd67, {5'd0, 32'd1000, 32'd234, 3'd0}, 0, 0, 1'b0, dc, rx, err, cap, ok);
    n_checks++; if (dc !== 102) $display("FAIL rmid_next_latency: got %0d want 102", dc); else n_pass++;
    n_checks++; if (rx !== 32'd1234 || ok !== 1'b1) $display("FAIL rmid_next_rx: got %0d ok=%b want 1234 1", rx, ok); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int dc; logic [31:0] rx; logic err; logic [71:0] cap; bit ok;
    do_txn(2'd0, 7'd67, {5'd0, 32'd3, 32'd4, 3'd0}, 0, 40, 1'b0, dc, rx, err, cap, ok);
`ifdef SPI_CTRL_TIMEOUT_EN
    n_checks++; if (dc !== 85) $display("FAIL tmo_latency: got %0d want 85", dc); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL tmo_error: got %b want 1", err); else n_pass++;
    n_checks++; if (rx !== 32'd1234 || ok !== 1'b1) $display("FAIL tmo_rx: got %0d ok=%b want 1234 1", rx, ok); else n_pass++;
`else
    n_checks++; if (dc !== 142) $display("FAIL wait_latency: got %0d want 142", dc); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL wait_error: got %b want 0", err); else n_pass++;
    n_checks++; if (rx !== 32'd7 || ok !== 1'b1) $display("FAIL wait_rx: got %0d ok=%b want 7 1", rx, ok); else n_pass++;
`endif
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) $display("FAIL tmo_ready: got %b want 1", ready); else n_pass++;
  endtask

  initial begin
    rst_n        = 1'b0;
    req          = 1'b0;
    slave        = 2'd0;
    tx_len       = 7'd0;
    tx_data      = '0;
    spi_bus.miso = 1'b0;
    test_reset();
    test_alu_add();
    test_delayed_slave();
    test_bad_slave();
    test_len_clamp();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
